// File: rtl/transceiver_tx_sequencer_pkg.sv
// Shared transceiver definitions: CC1101-style command bytes, chip status
// field location and the TX sequencer state encoding.
package transceiver_tx_sequencer_pkg;

  localparam logic [7:0] CMD_TXBURST = 8'h7F;
  localparam logic [7:0] CMD_STX     = 8'h35;
  localparam logic [7:0] CMD_SFTX    = 8'h3B;

  // Chip status byte: state field in [6:4], 3'b111 means TX FIFO underflow.
  localparam int         STATUS_MSB          = 6;
  localparam int         STATUS_LSB          = 4;
  localparam logic [2:0] STATUS_TX_UNDERFLOW = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_DATA,
    ST_STRB,
    ST_FLUSH,
    ST_DONE
  } tx_state_e;

endpackage

// File: rtl/transceiver_tx_sequencer_fifo.sv
// Synchronous byte FIFO with combinational head; DEPTH must be a power of 2
// (at least 2). Pushes while full are dropped; pops while empty are ignored.
module tx_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  always_comb begin
    push_ok  = push && (count_q != (AW+1)'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/transceiver_tx_sequencer.sv
// Buffers payload bytes and, on send, feeds header/length/payload/STX to the
// SPI byte engine; flushes the chip TX FIFO when the strobe status shows underflow.
module transceiver_tx_sequencer #(
  parameter int         DEPTH       = 64,
  parameter int         MAX_LEN     = 61,
  parameter logic [7:0] CMD_TXBURST = transceiver_tx_sequencer_pkg::CMD_TXBURST,
  parameter logic [7:0] CMD_STX     = transceiver_tx_sequencer_pkg::CMD_STX,
  parameter logic [7:0] CMD_SFTX    = transceiver_tx_sequencer_pkg::CMD_SFTX
) (
  input  logic                   CLK_48MHZ,
  input  logic                   BUF2_PBRST_T9,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   send,
  output logic                   busy,
  output logic                   spi_req,
  output logic [7:0]             spi_tx_byte,
  output logic                   spi_cs_hold,
  input  logic                   spi_ack,
  input  logic [7:0]             spi_rx_byte,
  output logic                   frame_done,
  output logic                   underflow_err
);
  import transceiver_tx_sequencer_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_e     state_q, state_d;
  logic          req_q, req_d;
  logic [7:0]    byte_q, byte_d;
  logic          hold_q, hold_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    rem_q, rem_d;
  logic          err_q, err_d;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic [7:0]    cur_byte;
  logic          cur_hold;
  logic [2:0]    rx_status;
  logic [4:0]    unused_rx_bits;

  assign rx_status      = spi_rx_byte[STATUS_MSB:STATUS_LSB];
  assign unused_rx_bits = {spi_rx_byte[7], spi_rx_byte[3:0]};

  tx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK_48MHZ),
    .rst_n     (BUF2_PBRST_T9),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (full)
  );

  // Byte offered for the current state once the post-ack gap cycle has passed.
  always_comb begin
    cur_byte = CMD_TXBURST;
    cur_hold = 1'b1;
    case (state_q)
      ST_LEN:   cur_byte = len_q;
      ST_DATA: begin
        cur_byte = fifo_head;
        cur_hold = (rem_q != 8'd1);
      end
      ST_STRB: begin
        cur_byte = CMD_STX;
        cur_hold = 1'b0;
      end
      ST_FLUSH: begin
        cur_byte = CMD_SFTX;
        cur_hold = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    byte_d   = byte_q;
    hold_d   = hold_q;
    len_d    = len_q;
    rem_d    = rem_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (send && (fifo_count != '0)) begin
          // Header goes out straight away so the first request follows send by one cycle.
          state_d = ST_HDR;
          req_d   = 1'b1;
          byte_d  = CMD_TXBURST;
          hold_d  = 1'b1;
          len_d   = (fifo_count > CW'(MAX_LEN)) ? 8'(MAX_LEN) : 8'(fifo_count);
          rem_d   = len_d;
          err_d   = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (!req_q) begin
          req_d  = 1'b1;
          byte_d = cur_byte;
          hold_d = cur_hold;
        end else if (spi_ack) begin
          req_d = 1'b0;
          case (state_q)
            ST_HDR: state_d = ST_LEN;
            ST_LEN: state_d = ST_DATA;
            ST_DATA: begin
              fifo_pop = 1'b1;
              rem_d    = rem_q - 8'd1;
              if (rem_q == 8'd1) state_d = ST_STRB;
            end
            ST_STRB: begin
              if (rx_status == STATUS_TX_UNDERFLOW) begin
                state_d = ST_FLUSH;
                err_d   = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (!BUF2_PBRST_T9) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      byte_q  <= 8'h00;
      hold_q  <= 1'b0;
      len_q   <= 8'h00;
      rem_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      byte_q  <= byte_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign count         = fifo_count;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = (state_q == ST_DONE);
  assign spi_req       = req_q;
  assign spi_tx_byte   = byte_q;
  assign spi_cs_hold   = hold_q;
  assign underflow_err = err_q;

endmodule

// File: doc/transceiver_tx_sequencer.md
Name: transceiver_tx_sequencer

Overview:
Upstream stage of the transceiver SPI master. Buffers outgoing payload bytes and, on command, emits the byte stream for one radio frame to the SPI byte engine:
- burst-write TX FIFO header
- length byte
- payload bytes
- STX strobe

Checks the chip status byte returned on MISO during the strobe and issues an SFTX flush on TX underflow.

Parameters:
DEPTH, 64, payload FIFO depth in bytes (power of 2)
MAX_LEN, 61, maximum payload bytes per frame
CMD_TXBURST, 8'h7F, burst-write TX FIFO header byte
CMD_STX, 8'h35, transmit strobe
CMD_SFTX, 8'h3B, flush TX FIFO strobe

Ports:
CLK_48MHZ  in  1  system clock, 48 MHz
BUF2_PBRST_T9  in  1  reset; synchronous, active-low
wr_en  in  1  push wr_data into payload FIFO
wr_data  in  8  payload byte
full  out  1  FIFO holds DEPTH bytes
count  out  $clog2(DEPTH)+1  FIFO occupancy
send  in  1  pulse: start one frame from current FIFO contents
busy  out  1  frame sequence in progress
spi_req  out  1  byte transfer request to SPI engine
spi_tx_byte  out  8  byte to shift out on MOSI
spi_cs_hold  out  1  keep SS low after this byte (burst continuation)
spi_ack  in  1  one-cycle pulse: current byte shifted
spi_rx_byte  in  8  byte captured from MISO; valid with spi_ack
frame_done  out  1  one-cycle pulse at end of sequence
underflow_err  out  1  sticky; set when flush issued; cleared by reset or next send

Behaviour:
- Reset (sync, BUF2_PBRST_T9=0 at clock edge):
  - FIFO emptied, count=0, full=0.
  - State IDLE.
  - Outputs: spi_req=0, spi_tx_byte=0, spi_cs_hold=0, busy=0, frame_done=0, underflow_err=0.
  - Reset mid-frame aborts immediately. No further bytes; the SPI engine sees req drop.
- FIFO:
  - wr_en with full=1: byte dropped, no state change.
  - Simultaneous push and pop: both occur, count unchanged.
  - Writes are accepted while busy. They belong to later frames.
- send is honoured only in IDLE with count>0.
  - Otherwise it is ignored: no req, no frame_done, underflow_err unchanged.
  - On accept: len = min(count, MAX_LEN) is latched, underflow_err is cleared, busy=1 from the next cycle.
- Handshake:
  - spi_req, spi_tx_byte and spi_cs_hold are held stable until the cycle spi_ack=1.
  - The FSM advances on ack. spi_req is 0 in the cycle after ack.
  - The next request is asserted 2 cycles after ack at the earliest.
  - spi_ack while spi_req=0 is ignored.
- States and transitions (all byte states advance on spi_ack):
  - IDLE: accepted send -> HDR.
  - HDR: byte CMD_TXBURST, cs_hold=1 -> LEN.
  - LEN: byte len, cs_hold=1 -> DATA.
  - DATA: byte is FIFO head.
    - The pop occurs on the ack cycle; a byte counter decrements.
    - cs_hold=1 except for the last byte (counter==1), where cs_hold=0.
    - Counter reaches 0 -> STRB.
  - STRB: byte CMD_STX, cs_hold=0.
    - spi_rx_byte[6:4]==3'b111 (TX underflow) -> FLUSH.
    - Otherwise -> DONE.
  - FLUSH: byte CMD_SFTX, cs_hold=0 -> DONE. underflow_err set on entry.
  - DONE: frame_done=1 for one cycle, busy=0 from the next cycle -> IDLE.
- Truncation: bytes beyond len stay in the FIFO for the next send.
- Latency: send accepted at cycle N -> first spi_req at N+1.

Decomposition:
- Shared transceiver package:
  - CC1101-style command constants (CMD_TXBURST, CMD_STX, CMD_SFTX)
  - status field position [6:4] and value 3'b111
  - FSM state encoding
- One sub-module: tx_byte_fifo. Synchronous byte FIFO parameterised by DEPTH with push, pop, head, count and full. The sequencer instantiates it.

Test Plan:
- Push 3 bytes A1,B2,C3, send, ack each request after 16 cycles with rx=8'h0F -> bytes 7F,03,A1,B2,C3,35; cs_hold 1,1,1,1,0,0; frame_done once; count=0; underflow_err=0.
- send with count=0 -> spi_req stays 0 for 50 cycles; busy=0; no frame_done.
- Push 70 bytes -> full=1 at 64, count=64; the extra 6 are dropped. Send -> len byte 8'h3D, 61 payload bytes; count=3 after frame_done.
- Strobe ack with spi_rx_byte=8'h70 -> extra byte 3B follows 35; underflow_err=1. The next accepted send clears it.
- Assert reset for one cycle during DATA after 2 payload acks -> next cycle spi_req=0, busy=0, count=0. A later send with empty FIFO is ignored.
- wr_en during DATA with a simultaneous pop -> count unchanged that cycle. The new byte is sent in the next frame with the correct length.
